// File: rtl/mnist_accel_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mnist_accel_pkg
//  Description : Shared types and constants for the MNIST CNN accelerator
//                datapath (accumulator / activation widths, requantisation
//                parameter record, INT8 saturation helper).
//  Revision    : 1.0  initial release
// ============================================================================
package mnist_accel_pkg;

    localparam int ACC_W       = 32;
    localparam int ACT_W       = 8;
    localparam int REQ_MULT_W  = 16;
    localparam int REQ_SHIFT_W = 5;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [ACT_W-1:0] act_t;

    // One row of the per-channel requantisation table at the default widths.
    typedef struct packed {
        acc_t                   bias;
        logic [REQ_MULT_W-1:0]  mult;
        logic [REQ_SHIFT_W-1:0] shift;
    } requant_param_t;

    // Clamp a wide signed value into INT8. With relu set the lower bound
    // becomes 0, so ReLU and saturation share a single comparator pair.
    function automatic act_t sat_act(input logic signed [63:0] v,
                                     input logic               relu);
        logic signed [63:0] w_lo;
        act_t               w_res;
        w_lo = relu ? 64'sd0 : 64'(INT8_MIN);
        if (v > 64'(INT8_MAX)) begin
            w_res = act_t'(INT8_MAX);
        end else if (v < w_lo) begin
            w_res = act_t'(w_lo);
        end else begin
            w_res = act_t'(v);
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/requant_param_rf.sv
`default_nettype none
// ============================================================================
//  Module      : requant_param_rf
//  Description : Per-output-channel requantisation parameter table.
//                NUM_CH rows of {bias, mult, shift}; one synchronous write
//                port (configuration) and one asynchronous read port indexed
//                by the running channel counter. Resets to the identity
//                transform (bias=0, mult=1, shift=0).
//  Revision    : 1.0  initial release
//
//  Ports
//    clk       in   system clock
//    rst_n     in   asynchronous active-low reset
//    wr_en     in   write strobe
//    wr_ch     in   row to write (rows >= NUM_CH are ignored)
//    wr_bias   in   signed bias
//    wr_mult   in   unsigned multiplier
//    wr_shift  in   right-shift amount
//    rd_ch     in   row to read
//    rd_bias   out  bias of row rd_ch
//    rd_mult   out  multiplier of row rd_ch
//    rd_shift  out  shift of row rd_ch
// ============================================================================
module requant_param_rf
    import mnist_accel_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_CH)-1:0] wr_ch,
    input  acc_t                      wr_bias,
    input  logic [MULT_W-1:0]         wr_mult,
    input  logic [SHIFT_W-1:0]        wr_shift,
    input  logic [$clog2(NUM_CH)-1:0] rd_ch,
    output acc_t                      rd_bias,
    output logic [MULT_W-1:0]         rd_mult,
    output logic [SHIFT_W-1:0]        rd_shift
);

    localparam int CH_W = $clog2(NUM_CH);

    acc_t               r_bias  [NUM_CH];
    logic [MULT_W-1:0]  r_mult  [NUM_CH];
    logic [SHIFT_W-1:0] r_shift [NUM_CH];

    logic w_wr_hit;

    // When NUM_CH is a power of two every index is legal, so the range
    // check only exists for the non-power-of-two case.
    if ((2 ** CH_W) == NUM_CH) begin : g_full_range
        assign w_wr_hit = wr_en;
    end else begin : g_partial_range
        assign w_wr_hit = wr_en && (wr_ch < CH_W'(NUM_CH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_bias[i]  <= '0;
                r_mult[i]  <= MULT_W'(1);
                r_shift[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_bias[wr_ch]  <= wr_bias;
            r_mult[wr_ch]  <= wr_mult;
            r_shift[wr_ch] <= wr_shift;
        end
    end

    // Combinational read: the row is captured into stage 1 together with the
    // accepted beat, so a write landing on the same edge is not yet visible.
    assign rd_bias  = r_bias[rd_ch];
    assign rd_mult  = r_mult[rd_ch];
    assign rd_shift = r_shift[rd_ch];

endmodule
`default_nettype wire

// File: rtl/requant_int8.sv
`default_nettype none
// ============================================================================
//  Module      : requant_int8
//  Description : Requantises 32-bit signed accumulator beats from the mac8
//                array to signed INT8 activations. Per-channel bias add,
//                unsigned fixed-point multiply, rounding right shift, optional
//                ReLU and saturation, in a 3-stage pipeline with a
//                valid/ready handshake and global-stall backpressure.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   system clock
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   accumulator beat valid
//    in_ready   out  beat can be accepted this cycle
//    in_acc     in   signed accumulator value
//    in_last    in   final beat of current group (restarts channel count)
//    cfg_we     in   parameter table write strobe
//    cfg_ch     in   channel row to write
//    cfg_bias   in   signed bias
//    cfg_mult   in   unsigned multiplier
//    cfg_shift  in   right-shift amount
//    relu_en    in   clamp negatives to zero (sampled with each beat)
//    out_valid  out  requantised beat valid
//    out_ready  in   consumer accepts beat
//    out_data   out  signed INT8 result
//    out_last   out  in_last carried with its beat
// ============================================================================
module requant_int8
    import mnist_accel_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [ACC_W-1:0]   in_acc,
    input  logic                      in_last,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic signed [ACC_W-1:0]   cfg_bias,
    input  logic [MULT_W-1:0]         cfg_mult,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    input  logic                      relu_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [ACT_W-1:0]   out_data,
    output logic                      out_last
);

    localparam int CH_W = $clog2(NUM_CH);
    // Datapath widths chosen so no stage can overflow:
    //   bias add needs one extra bit, the product of a 33-bit signed value and
    //   a zero-extended unsigned multiplier needs 33+MULT_W+1 bits, and the
    //   rounding add needs one more.
    localparam int c_sum_w  = ACC_W + 1;
    localparam int c_prod_w = c_sum_w + MULT_W + 1;
    localparam int c_rnd_w  = c_prod_w + 1;
    localparam logic [CH_W-1:0] c_ch_max = CH_W'(NUM_CH - 1);

    // ------------------------------------------------------------------
    // Handshake / stall
    // ------------------------------------------------------------------
    logic r_out_valid;
    logic w_adv;
    logic w_accept;

    // Single global enable: the whole pipe freezes only while a result is
    // sitting on the output unconsumed. Bubbles travel with the data.
    assign w_adv    = !(r_out_valid && !out_ready);
    assign w_accept = in_valid && w_adv;
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // Channel counter
    // ------------------------------------------------------------------
    logic [CH_W-1:0] r_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch <= '0;
        end else if (w_accept) begin
            if (in_last || (r_ch == c_ch_max)) begin
                r_ch <= '0;
            end else begin
                r_ch <= r_ch + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Parameter table
    // ------------------------------------------------------------------
    acc_t               w_rd_bias;
    logic [MULT_W-1:0]  w_rd_mult;
    logic [SHIFT_W-1:0] w_rd_shift;

    requant_param_rf #(
        .NUM_CH  (NUM_CH),
        .MULT_W  (MULT_W),
        .SHIFT_W (SHIFT_W)
    ) u_param_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (cfg_we),
        .wr_ch    (cfg_ch),
        .wr_bias  (cfg_bias),
        .wr_mult  (cfg_mult),
        .wr_shift (cfg_shift),
        .rd_ch    (r_ch),
        .rd_bias  (w_rd_bias),
        .rd_mult  (w_rd_mult),
        .rd_shift (w_rd_shift)
    );

    // ------------------------------------------------------------------
    // Stage 1: bias add (computed on the way in)
    // ------------------------------------------------------------------
    logic signed [c_sum_w-1:0] w_sum;

    assign w_sum = {in_acc[ACC_W-1], in_acc} + {w_rd_bias[ACC_W-1], w_rd_bias};

    logic                      r_s1_valid;
    logic signed [c_sum_w-1:0] r_s1_sum;
    logic [MULT_W-1:0]         r_s1_mult;
    logic [SHIFT_W-1:0]        r_s1_shift;
    logic                      r_s1_relu;
    logic                      r_s1_last;

    // ------------------------------------------------------------------
    // Stage 2: multiply. Operands are extended to the full product width
    // before the multiply so the result is computed at that width.
    // ------------------------------------------------------------------
    logic signed [c_prod_w-1:0] w_prod;

    assign w_prod = $signed({{(c_prod_w - c_sum_w){r_s1_sum[c_sum_w-1]}}, r_s1_sum})
                  * $signed({{(c_prod_w - MULT_W){1'b0}}, r_s1_mult});

    logic                       r_s2_valid;
    logic signed [c_prod_w-1:0] r_s2_prod;
    logic [SHIFT_W-1:0]         r_s2_shift;
    logic                       r_s2_relu;
    logic                       r_s2_last;

    // ------------------------------------------------------------------
    // Stage 3: round-half-up shift, then clamp. With shift=0 the rounding
    // constant is zero and the shift is a no-op, so one path covers both.
    // ------------------------------------------------------------------
    logic signed [c_rnd_w-1:0] w_prod_ext;
    logic signed [c_rnd_w-1:0] w_round;
    logic signed [c_rnd_w-1:0] w_rnd;
    logic signed [c_rnd_w-1:0] w_scaled;
    act_t                      w_sat;

    assign w_prod_ext = {r_s2_prod[c_prod_w-1], r_s2_prod};
    assign w_round    = (r_s2_shift == '0) ? '0
                      : (c_rnd_w'(1) << (r_s2_shift - SHIFT_W'(1)));
    assign w_rnd      = w_prod_ext + w_round;
    assign w_scaled   = w_rnd >>> r_s2_shift;
    assign w_sat      = sat_act({{(64 - c_rnd_w){w_scaled[c_rnd_w-1]}}, w_scaled},
                                r_s2_relu);

    logic r_out_last;
    act_t r_out_data;

    // ------------------------------------------------------------------
    // Pipeline registers. Payload registers load only behind a valid beat;
    // valid bits always shift so bubbles are preserved.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_sum    <= '0;
            r_s1_mult   <= '0;
            r_s1_shift  <= '0;
            r_s1_relu   <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_prod   <= '0;
            r_s2_shift  <= '0;
            r_s2_relu   <= 1'b0;
            r_s2_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sum   <= w_sum;
                r_s1_mult  <= w_rd_mult;
                r_s1_shift <= w_rd_shift;
                r_s1_relu  <= relu_en;
                r_s1_last  <= in_last;
            end

            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_prod  <= w_prod;
                r_s2_shift <= r_s1_shift;
                r_s2_relu  <= r_s1_relu;
                r_s2_last  <= r_s1_last;
            end

            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_data <= w_sat;
                r_out_last <= r_s2_last;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_requant_int8.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_requant_int8
//  Description : Self-checking bench for requant_int8. Directed phases for
//                identity, scale/round, ReLU, channel wrap/last, backpressure
//                and mid-stream reset, followed by a randomised phase checked
//                against an arithmetic reference model and scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_requant_int8;

    localparam int NUM_CH  = 16;
    localparam int MULT_W  = 16;
    localparam int SHIFT_W = 5;
    localparam int CH_W    = 4;

    logic                     clk       = 1'b0;
    logic                     rst_n     = 1'b0;
    logic                     in_valid  = 1'b0;
    logic                     in_last   = 1'b0;
    logic signed [31:0]       in_acc    = '0;
    logic                     cfg_we    = 1'b0;
    logic [CH_W-1:0]          cfg_ch    = '0;
    logic signed [31:0]       cfg_bias  = '0;
    logic [MULT_W-1:0]        cfg_mult  = 16'd1;
    logic [SHIFT_W-1:0]       cfg_shift = '0;
    logic                     relu_en   = 1'b0;
    logic                     out_ready = 1'b1;
    logic                     in_ready;
    logic                     out_valid;
    logic signed [7:0]        out_data;
    logic                     out_last;

    always #5 clk = ~clk;

    requant_int8 #(
        .NUM_CH  (NUM_CH),
        .MULT_W  (MULT_W),
        .SHIFT_W (SHIFT_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_bias  (cfg_bias),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int data;
        bit last;
    } beat_t;

    beat_t  exp_q[$];
    beat_t  obs_q[$];

    // Reference parameter table and channel pointer.
    longint m_bias  [NUM_CH];
    longint m_mult  [NUM_CH];
    int     m_shift [NUM_CH];
    int     m_ch = 0;

    bit                stall_prev = 1'b0;
    logic signed [7:0] hold_data;
    logic              hold_last;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Requantisation straight from the arithmetic definition.
    function automatic int ref_requant(longint acc, longint bias, longint mult,
                                       int shift, bit relu);
        longint s, p, r, lo;
        s = acc + bias;
        p = s * mult;
        if (shift == 0) r = p;
        else            r = (p + (longint'(1) << (shift - 1))) >>> shift;
        lo = relu ? 0 : -128;
        if (r > 127)     r = 127;
        else if (r < lo) r = lo;
        return int'(r);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_bias[i]  = 0;
            m_mult[i]  = 1;
            m_shift[i] = 0;
        end
        m_ch = 0;
        exp_q.delete();
    endfunction

    // Monitor / scoreboard, sampling mid-cycle where inputs and outputs are
    // stable for the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_data);
                chk("hold_last", out_last, hold_last);
            end
            if (out_valid && out_ready) begin
                beat_t o;
                o.data = int'(out_data);
                o.last = out_last;
                obs_q.push_back(o);
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_errors++;
                    $error("FAIL unexpected_out: observed=%0d expected=none", out_data);
                end
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("sb_data", out_data, e.data);
                    chk("sb_last", out_last, e.last);
                end
            end
            if (in_valid && in_ready) begin
                beat_t e;
                e.data = ref_requant(longint'(in_acc), m_bias[m_ch], m_mult[m_ch],
                                     m_shift[m_ch], relu_en);
                e.last = in_last;
                exp_q.push_back(e);
                m_ch = in_last ? 0 : (m_ch + 1) % NUM_CH;
            end
            // A write on this edge is only visible to later beats.
            if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
                m_bias[cfg_ch]  = longint'(cfg_bias);
                m_mult[cfg_ch]  = longint'(cfg_mult);
                m_shift[cfg_ch] = int'(cfg_shift);
            end
            stall_prev = out_valid && !out_ready;
            hold_data  = out_data;
            hold_last  = out_last;
        end
    end

    task automatic send(input int acc, input bit last);
        int n;
        bit took;
        n = 0;
        took = 1'b0;
        in_valid = 1'b1;
        in_acc   = acc;
        in_last  = last;
        while (!took && n < 200) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accept", took, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic cfg(input int ch, input int bias, input int mult, input int shift);
        cfg_we    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_bias  = bias;
        cfg_mult  = MULT_W'(mult);
        cfg_shift = SHIFT_W'(shift);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_obs(input int n, input string tag);
        int c;
        c = 0;
        while (obs_q.size() < n && c < 200) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk(tag, obs_q.size(), n);
    endtask

    task automatic chk_obs(input string tag, input int idx, input int exp_data);
        beat_t b;
        if (idx < obs_q.size()) b = obs_q[idx];
        else begin
            b.data = -999;
            b.last = 1'b0;
        end
        chk(tag, b.data, exp_data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int exp_ch[24];
        int e;
        bit took;
        int k;
        int c;

        // ---------------- Reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- Latency ----------------
        send(42, 1'b1);
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk("latency", lat, 3);
        chk("latency_data", out_data, 42);
        @(posedge clk);
        #1;

        // ---------------- Identity ----------------
        repeat (3) @(posedge clk);
        #1;
        obs_q.delete();
        send(100, 1'b0);
        send(-5, 1'b0);
        send(300, 1'b0);
        send(-300, 1'b1);
        wait_obs(4, "id_count");
        chk_obs("id_0", 0, 100);
        chk_obs("id_1", 1, -5);
        chk_obs("id_2", 2, 127);
        chk_obs("id_3", 3, -128);

        // ---------------- Scale / round ----------------
        obs_q.delete();
        cfg(0, 10, 3, 2);
        send(5, 1'b1);
        send(-19, 1'b1);
        wait_obs(2, "scale_count");
        chk_obs("scale_pos", 0, 11);
        chk_obs("scale_neg", 1, -7);

        // ---------------- ReLU ----------------
        obs_q.delete();
        cfg(0, 0, 1, 0);
        relu_en = 1'b1;
        send(-50, 1'b1);
        send(90, 1'b1);
        wait_obs(2, "relu_count");
        chk_obs("relu_neg", 0, 0);
        chk_obs("relu_pos", 1, 90);
        relu_en = 1'b0;

        // ---------------- Channel wrap / last ----------------
        for (int i = 0; i < NUM_CH; i++) cfg(i, i, 1, 0);
        obs_q.delete();
        e = 0;
        for (int i = 0; i < 24; i++) begin
            exp_ch[i] = e;
            e = (i == 5) ? 0 : (e + 1) % NUM_CH;
        end
        for (int i = 0; i < 24; i++) send(0, i == 5);
        wait_obs(24, "chan_count");
        for (int i = 0; i < 24; i++) chk_obs($sformatf("chan_%0d", i), i, exp_ch[i]);

        // ---------------- Backpressure ----------------
        obs_q.delete();
        k = 0;
        c = 0;
        while (k < 8 && c < 100) begin
            out_ready = !(c >= 3 && c < 7);
            in_valid  = 1'b1;
            in_acc    = int'($urandom_range(0, 200)) - 100;
            in_last   = (k == 7);
            @(negedge clk);
            if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
            if (in_ready) k++;
            @(posedge clk);
            #1;
            c++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent", k, 8);
        wait_obs(8, "bp_count");
        for (int i = 0; i < 8; i++) begin
            beat_t b;
            b.last = 1'b0;
            if (i < obs_q.size()) b = obs_q[i];
            chk($sformatf("bp_last_%0d", i), b.last, (i == 7));
        end

        // ---------------- Reset mid-stream ----------------
        obs_q.delete();
        send(11, 1'b0);
        send(12, 1'b0);
        send(13, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_rst_no_emit", obs_q.size(), 0);
        cfg(0, 7, 1, 0);
        cfg(3, 30, 1, 0);
        send(1, 1'b1);
        wait_obs(1, "mid_rst_count");
        chk_obs("mid_rst_ch0", 0, 8);

        // ---------------- Randomised ----------------
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                case ($urandom_range(0, 2))
                    0:       in_acc = $urandom;
                    1:       in_acc = int'($urandom_range(0, 4000)) - 2000;
                    default: in_acc = int'($urandom_range(0, 400)) - 200;
                endcase
                in_last = ($urandom_range(0, 7) == 0);
            end
            cfg_we = ($urandom_range(0, 9) == 0);
            if (cfg_we) begin
                cfg_ch    = CH_W'($urandom);
                cfg_bias  = ($urandom_range(0, 3) == 0) ? $urandom
                                                        : int'($urandom_range(0, 200)) - 100;
                cfg_mult  = MULT_W'($urandom);
                cfg_shift = SHIFT_W'($urandom);
            end
            if ($urandom_range(0, 49) == 0) relu_en = ~relu_en;
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            cfg_we = 1'b0;
        end

        // Drain whatever is still held or in flight.
        c = 0;
        while (in_valid && c < 100) begin
            out_ready = 1'b1;
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            c++;
        end
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
